relay_bank: RTL

- N-channel clocked relay bank; successor to the two-relay combination bench.
- Each channel models an electromechanical relay with finite pull-in and drop-out times, driven by its own switch and battery inputs.
- Contacts combine into one output, either series (AND) or parallel (OR), selected at run time.
- Feeds relay-logic gate builds (AND/OR/latch experiments) where contact timing must be visible in VCDs.

---
 rtl/relay_bank.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/relay_bank.sv
// ---------------------------------------------------------------------------
// relay_bank
//
// N-channel clocked model of electromechanical relays. Each channel has a coil
// that is energised when switch[i] & batt[i]. The contact closes only after
// the coil has been held energised for PULL_CYCLES further edges. It opens
// only after the coil has been held off for DROP_CYCLES further edges. The
// contacts combine into a single output that is either series (AND) or
// parallel (OR). A saturating counter records the rising edges of that output.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset    - synchronous, active-high reset
//   switch   - [N] per-channel coil switch
//   batt     - [N] per-channel coil supply
//   mode     - 0 = series (AND of contacts), 1 = parallel (OR of contacts)
//   contact  - [N] registered per-channel contact state, 1 = closed
//   out      - combined contact output, combinational from contact and mode
//   settled  - 1 when no channel is mid pull-in or mid release
//   closures - [CNT_W] saturating count of out rising edges
// ---------------------------------------------------------------------------
module relay_bank #(
    parameter int N           = 2,
    parameter int PULL_CYCLES = 3,
    parameter int DROP_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     switch,
    input  logic [N-1:0]     batt,
    input  logic             mode,
    output logic [N-1:0]     contact,
    output logic             out,
    output logic             settled,
    output logic [CNT_W-1:0] closures
);

    // The timer only ever holds values up to max(PULL, DROP) - 1.
    localparam int MAX_CYC = (PULL_CYCLES > DROP_CYCLES) ? PULL_CYCLES : DROP_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] PULL_LOAD = TMR_W'(PULL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DROP_LOAD = TMR_W'(DROP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic [1:0] {
        OPEN      = 2'd0,
        PULLING   = 2'd1,
        CLOSED    = 2'd2,
        RELEASING = 2'd3
    } relay_state_t;

    relay_state_t     state [N];
    logic [TMR_W-1:0] timer [N];
    logic [N-1:0]     energised;
    logic             out_p1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign energised = switch & batt;

    // Per-channel relay FSMs. contact is written together with the state
    // transition, so it is always a registered image of CLOSED/RELEASING.
    // An aborted pull-in returns to OPEN without touching contact. A re-grab
    // during release returns to CLOSED, and contact never drops.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                state[i]   <= OPEN;
                timer[i]   <= '0;
                contact[i] <= 1'b0;
            end else begin
                case (state[i])
                    OPEN: begin
                        if (energised[i]) begin
                            state[i] <= PULLING;
                            timer[i] <= PULL_LOAD;
                        end
                    end
                    PULLING: begin
                        if (!energised[i]) begin
                            state[i] <= OPEN;
                        end else if (timer[i] == '0) begin
                            state[i]   <= CLOSED;
                            contact[i] <= 1'b1;
                        end else begin
                            timer[i] <= timer[i] - TMR_ONE;
                        end
                    end
                    CLOSED: begin
                        if (!energised[i]) begin
                            state[i] <= RELEASING;
                            timer[i] <= DROP_LOAD;
                        end
                    end
                    RELEASING: begin
                        if (energised[i]) begin
                            state[i] <= CLOSED;
                        end else if (timer[i] == '0) begin
                            state[i]   <= OPEN;
                            contact[i] <= 1'b0;
                        end else begin
                            timer[i] <= timer[i] - TMR_ONE;
                        end
                    end
                    default: begin
                        state[i]   <= OPEN;
                        timer[i]   <= '0;
                        contact[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        settled = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (state[i] == PULLING || state[i] == RELEASING) begin
                settled = 1'b0;
            end
        end
    end

    // Combine rule: mode changes show up on out with no clock delay.
    always_comb begin
        out = mode ? (|contact) : (&contact);
    end

    // Stage boundary: out_p1 holds out from the previous cycle. A rise is
    // detected on the current cycle's out, so rises caused by a mode change
    // are counted as well as rises caused by a contact closing.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_p1   <= 1'b0;
            closures <= '0;
        end else begin
            out_p1 <= out;
            if (out && !out_p1) begin
                closures <= sat_inc(closures);
            end
        end
    end

endmodule
